// File: rtl/retospect_cfg_pkg.sv
// Shared definitions for the Retospect configuration-chain loader.
// Holds the loader state encoding and the chain geometry: six clock
// registers of 8 bits followed by 50 neuron cells of 19 bits each.
// The build macro CFG_READBACK_EN adds the VERIFY state to the encoding.
package retospect_cfg_pkg;

    localparam int CELL_BITS = 19;
    localparam int CLK_BITS  = 48;
    localparam int N_CELLS   = 50;
    localparam int CHAIN_LEN = CLK_BITS + N_CELLS * CELL_BITS;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_INIT   = 3'd3,
        ST_FIN    = 3'd4
`ifdef CFG_READBACK_EN
        , ST_VERIFY = 3'd5
`endif
    } cfg_state_e;

endpackage

// File: rtl/retospect_byte_serializer.sv
// Parallel-in / serial-out holding register for one host configuration byte.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   load        - capture data_in and restart at bit 0
//   shift       - advance to the next bit (LSB first)
//   data_in     - host byte, sampled only while load is high
//   bit_out     - currently selected bit of the held byte
//   bit_idx     - index of the currently selected bit
//   last_bit    - high while bit 7 is selected
module retospect_byte_serializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] data_in,
    output logic       bit_out,
    output logic [2:0] bit_idx,
    output logic       last_bit
);

    logic [7:0] data_q;
    logic [7:0] data_d;
    logic [2:0] idx_q;
    logic [2:0] idx_d;

    // Load has priority so a fresh byte always starts from its LSB.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        if (load) begin
            data_d = data_in;
            idx_d  = 3'd0;
        end else if (shift) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'd0;
            idx_q  <= 3'd0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
        end
    end

    assign bit_out  = data_q[idx_q];
    assign bit_idx  = idx_q;
    assign last_bit = (idx_q == 3'd7);

endmodule

// File: rtl/retospect_cfg_loader.sv
// Streams host configuration bytes into the Retospect serial configuration
// chain, then pulses reset_nn once to initialise the neuron potentials.
// Build macro: CFG_READBACK_EN adds a VERIFY pass that recirculates the chain
// through bs_ret while comparing it to a resent byte stream.
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   start             - begins a load when idle (also begins VERIFY with readback)
//   s_data/s_valid    - host byte stream, LSB shifted first
//   s_ready           - high only while waiting for the next byte
//   config_en, bs_in  - chain shift enable and serial data into the chain
//   bs_ret            - serial data returned from the chain tail
//   reset_nn          - one-cycle neuron initialise pulse after the last shift
//   busy, done, err   - status; done and err hold until the next accepted start
module retospect_cfg_loader
    import retospect_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = retospect_cfg_pkg::CHAIN_LEN,
    parameter int CNT_W     = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       config_en,
    output logic       bs_in,
    input  logic       bs_ret,
    output logic       reset_nn,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);

    cfg_state_e       state_q;
    cfg_state_e       state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic             done_q;
    logic             done_d;
    logic             err_q;
    logic             err_d;

    logic             ser_load;
    logic             ser_shift;
    logic             ser_bit;
    logic             ser_last;
    logic [2:0]       ser_idx_unused;

`ifdef CFG_READBACK_EN
    logic             verify_q;
    logic             verify_d;
    logic             init_pulsed_q;
    logic             init_pulsed_d;
`else
    logic             bs_ret_unused;
    assign bs_ret_unused = bs_ret;
`endif

    retospect_byte_serializer u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .shift    (ser_shift),
        .data_in  (s_data),
        .bit_out  (ser_bit),
        .bit_idx  (ser_idx_unused),
        .last_bit (ser_last)
    );

    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

    // Next-state and output decode. The chain-end test uses the incremented
    // count so the final partial byte stops exactly at the last chain bit and
    // its remaining bits are never shifted.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        s_ready   = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;
        reset_nn  = 1'b0;
`ifdef CFG_READBACK_EN
        verify_d      = verify_q;
        init_pulsed_d = init_pulsed_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
`ifdef CFG_READBACK_EN
                    verify_d      = 1'b0;
                    init_pulsed_d = 1'b0;
`endif
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    ser_load = 1'b1;
`ifdef CFG_READBACK_EN
                    state_d  = verify_q ? ST_VERIFY : ST_SHIFT;
`else
                    state_d  = ST_SHIFT;
`endif
                end else if (bit_cnt_q != '0) begin
                    // A stall mid-chain leaves config_en low, so the neuron
                    // dynamics may disturb bits already in the chain.
                    err_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                config_en = 1'b1;
                bs_in     = ser_bit;
                ser_shift = 1'b1;
                bit_cnt_d = bit_cnt_inc;
                if (bit_cnt_inc == LAST_CNT) begin
                    state_d = ST_INIT;
                end else if (ser_last) begin
                    state_d = ST_FETCH;
                end
            end
            ST_INIT: begin
`ifdef CFG_READBACK_EN
                // Pulse once, then hold here until the host asks for readback.
                reset_nn      = !init_pulsed_q;
                init_pulsed_d = 1'b1;
                if (start) begin
                    bit_cnt_d     = '0;
                    verify_d      = 1'b1;
                    init_pulsed_d = 1'b0;
                    state_d       = ST_FETCH;
                end
`else
                reset_nn = 1'b1;
                state_d  = ST_FIN;
`endif
            end
`ifdef CFG_READBACK_EN
            ST_VERIFY: begin
                // Recirculate the tail into the head so the chain ends unchanged.
                config_en = 1'b1;
                bs_in     = bs_ret;
                ser_shift = 1'b1;
                bit_cnt_d = bit_cnt_inc;
                if (bs_ret != ser_bit) begin
                    err_d = 1'b1;
                end
                if (bit_cnt_inc == LAST_CNT) begin
                    state_d = ST_FIN;
                end else if (ser_last) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef CFG_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify_q      <= 1'b0;
            init_pulsed_q <= 1'b0;
        end else begin
            verify_q      <= verify_d;
            init_pulsed_q <= init_pulsed_d;
        end
    end
`endif

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule
